// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds the 10-bit symbol boundary by hunting for control
// tokens, then decodes DVI characters back to pixel data, DE and C0/C1.
module tmds_channel_decoder #(
  parameter int CTRL_RUN     = 16,
  parameter int SEARCH_WIN   = 4096,
  parameter int LOCK_TIMEOUT = 1048576
) (
  input  logic       PCLKX1_i,
  input  logic       RSTn_i,
  input  logic [9:0] RAW_i,
  output logic [7:0] D_O,
  output logic       C0_O,
  output logic       C1_O,
  output logic       DE_O,
  output logic       LOCKED_O,
  output logic [3:0] OFFSET_O
);
  localparam int WW = $clog2(SEARCH_WIN);
  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam int RW = $clog2(CTRL_RUN + 1);

  localparam logic [WW-1:0] WIN_LAST = WW'(SEARCH_WIN - 1);
  localparam logic [TW-1:0] WD_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(CTRL_RUN);
  localparam logic [RW-1:0] RUN_LAST = RW'(CTRL_RUN - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state, state_n;
  logic [9:0]    raw_r, s1, aligned;
  logic [RW-1:0] tok_run, tok_run_n;
  logic [WW-1:0] win_cnt, win_n;
  logic [TW-1:0] wd_cnt, wd_n;
  logic [3:0]    offset, off_n, off_inc;
  logic [1:0]    flush, flush_n, tok_c, c_last;
  logic          is_tok, live_tok;
  logic [7:0]    q, dec;

  assign aligned  = 10'({RAW_i, raw_r} >> offset);
  assign off_inc  = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
  // S1 still holds a word aligned at the old offset right after a move
  assign live_tok = is_tok && (flush == 2'd0);
  assign LOCKED_O = (state == LOCKED);
  assign OFFSET_O = offset;

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (s1)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  always_comb begin
    q      = s1[9] ? ~s1[7:0] : s1[7:0];
    dec    = '0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++)
      dec[i] = s1[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
  end

  always_comb begin
    state_n   = state;
    tok_run_n = tok_run;
    win_n     = win_cnt;
    wd_n      = wd_cnt;
    off_n     = offset;
    flush_n   = (flush != 2'd0) ? flush - 2'd1 : 2'd0;
    case (state)
      SEARCH: begin
        win_n     = win_cnt + 1'b1;
        tok_run_n = live_tok ? ((tok_run == RUN_MAX) ? tok_run : tok_run + 1'b1) : '0;
        if (live_tok && tok_run == RUN_LAST) begin
          state_n = LOCKED;
          wd_n    = '0;
        end else if (win_cnt == WIN_LAST) begin
          off_n     = off_inc;
          tok_run_n = '0;
          win_n     = '0;
          flush_n   = 2'd2;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          wd_n = '0;
        end else if (wd_cnt == WD_LAST) begin
          state_n   = SEARCH;
          tok_run_n = '0;
          win_n     = '0;
          off_n     = off_inc;
          flush_n   = 2'd2;
        end else begin
          wd_n = wd_cnt + 1'b1;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge PCLKX1_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state   <= SEARCH;
      tok_run <= '0;
      win_cnt <= '0;
      wd_cnt  <= '0;
      offset  <= '0;
      flush   <= '0;
    end else begin
      state   <= state_n;
      tok_run <= tok_run_n;
      win_cnt <= win_n;
      wd_cnt  <= wd_n;
      offset  <= off_n;
      flush   <= flush_n;
    end
  end

  // Output mask uses the pre-edge lock state, so outputs trail LOCKED_O by one cycle
  always_ff @(posedge PCLKX1_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      raw_r  <= '0;
      s1     <= '0;
      c_last <= '0;
      D_O    <= '0;
      C0_O   <= 1'b0;
      C1_O   <= 1'b0;
      DE_O   <= 1'b0;
    end else begin
      raw_r <= RAW_i;
      s1    <= aligned;
      if (is_tok) c_last <= tok_c;
      if (!LOCKED_O) begin
        D_O  <= '0;
        C0_O <= 1'b0;
        C1_O <= 1'b0;
        DE_O <= 1'b0;
      end else if (is_tok) begin
        D_O  <= '0;
        C0_O <= tok_c[0];
        C1_O <= tok_c[1];
        DE_O <= 1'b0;
      end else begin
        D_O  <= dec;
        C0_O <= c_last[0];
        C1_O <= c_last[1];
        DE_O <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: random-framed TMDS streams, a reference model
// feeding a scoreboard queue, and a per-cycle monitor.
module tb_tmds_channel_decoder;
  localparam int CTRL_RUN = 16, SEARCH_WIN = 64, LOCK_TIMEOUT = 256;

  logic       PCLKX1_i = 1'b0;
  logic       RSTn_i   = 1'b0;
  logic [9:0] RAW_i    = '0;
  logic [7:0] D_O;
  logic       C0_O, C1_O, DE_O, LOCKED_O;
  logic [3:0] OFFSET_O;

  tmds_channel_decoder #(
    .CTRL_RUN(CTRL_RUN), .SEARCH_WIN(SEARCH_WIN), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .PCLKX1_i(PCLKX1_i), .RSTn_i(RSTn_i), .RAW_i(RAW_i),
    .D_O(D_O), .C0_O(C0_O), .C1_O(C1_O), .DE_O(DE_O),
    .LOCKED_O(LOCKED_O), .OFFSET_O(OFFSET_O)
  );

  always #5 PCLKX1_i = ~PCLKX1_i;

  int total = 0, bad = 0;
  logic [15:0] exp_q[$];
  bit started = 0;
  logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  function automatic int tok_idx(input logic [9:0] w);
    for (int k = 0; k < 4; k++) if (w == tok_tab[k]) return k;
    return -1;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom);
    if (tok_idx(w) >= 0) w = 10'h100;
    return w;
  endfunction

  // ---------------- reference model ----------------
  logic [9:0] m_raw_r, m_s1;
  logic [1:0] m_c;
  int m_off, m_run, m_win, m_quiet, m_flush;
  bit m_lock;

  task automatic m_reset();
    m_raw_r = '0; m_s1 = '0; m_c = '0;
    m_off = 0; m_run = 0; m_win = 0; m_quiet = 0; m_flush = 0; m_lock = 0;
  endtask

  task automatic m_step(input logic [9:0] raw);
    logic [19:0] cat;
    logic [9:0]  a;
    logic [7:0]  b, d;
    logic [10:0] o;
    int ti;
    bit ign;
    cat = {raw, m_raw_r};
    a   = 10'(cat >> m_off);
    ti  = tok_idx(m_s1);
    b   = m_s1[9] ? ~m_s1[7:0] : m_s1[7:0];
    d   = b ^ {b[6:0], 1'b0} ^ (m_s1[8] ? 8'h00 : 8'hFE);
    if (!m_lock)     o = '0;
    else if (ti >= 0) o = {1'b0, 2'(ti), 8'h00};
    else             o = {1'b1, m_c, d};
    if (ti >= 0) m_c = 2'(ti);
    ign = (m_flush != 0);
    if (m_flush > 0) m_flush--;
    if (!m_lock) begin
      if (ti >= 0 && !ign && m_run + 1 >= CTRL_RUN) begin
        m_lock = 1; m_quiet = 0;
      end else if (m_win == SEARCH_WIN - 1) begin
        m_off = (m_off + 1) % 10; m_run = 0; m_win = 0; m_flush = 2;
      end else begin
        m_win++;
        m_run = (ti >= 0 && !ign) ? m_run + 1 : 0;
      end
    end else begin
      if (ti >= 0) m_quiet = 0;
      else if (m_quiet == LOCK_TIMEOUT - 1) begin
        m_lock = 0; m_off = (m_off + 1) % 10; m_run = 0; m_win = 0; m_flush = 2;
      end else m_quiet++;
    end
    m_s1 = a;
    m_raw_r = raw;
    exp_q.push_back({m_lock, 4'(m_off), o});
  endtask

  initial m_reset();

  always @(posedge PCLKX1_i) begin
    if (!RSTn_i) begin
      m_reset();
      exp_q.push_back('0);
    end else m_step(RAW_i);
    started = 1;
  end

  always @(negedge RSTn_i) begin
    m_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
  end

  // ---------------- monitor ----------------
  always @(negedge PCLKX1_i) begin : mon
    logic [15:0] e, a;
    if (started) begin
      a = {LOCKED_O, OFFSET_O, DE_O, C1_O, C0_O, D_O};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty t=%0t got=%h", $time, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got={lk,off,de,c1,c0,d}=%h want=%h", $time, a, e);
        end
      end
    end
  end

  // ---------------- stream driver ----------------
  int shift = 3;
  bit regen = 1, fill_tok = 0;
  logic [9:0] sym_q[$];
  logic [63:0] sbuf = '0;
  int nb = 0;

  always @(negedge PCLKX1_i) begin : drv
    logic [9:0] s;
    if (regen) begin
      sbuf = {32'h0, $urandom} & ((64'd1 << shift) - 64'd1);
      nb = shift;
      regen = 0;
    end
    while (nb < 10) begin
      if (sym_q.size() > 0) s = sym_q.pop_front();
      else if (fill_tok)    s = 10'h354;
      else                  s = rand_data();
      sbuf |= {54'h0, s} << nb;
      nb += 10;
    end
    RAW_i = sbuf[9:0];
    sbuf >>= 10;
    nb -= 10;
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_lock(input bit want, input int lim, input string nm);
    int n;
    n = 0;
    while (LOCKED_O !== want && n < lim) begin @(negedge PCLKX1_i); n++; end
    chk(nm, int'(LOCKED_O === want), 1);
  endtask

  task automatic wait_off(input int want, input int lim, input string nm);
    int n;
    n = 0;
    while (int'(OFFSET_O) != want && n < lim) begin @(negedge PCLKX1_i); n++; end
    chk(nm, int'(OFFSET_O), want);
  endtask

  initial begin : main
    int n;
    repeat (5) begin
      @(negedge PCLKX1_i);
      chk("rst_locked", LOCKED_O, 0);
      chk("rst_offset", OFFSET_O, 0);
      chk("rst_de", DE_O, 0);
      chk("rst_d", D_O, 0);
    end
    RSTn_i = 1'b1;
    fill_tok = 1;

    wait_lock(1, 400, "lock_shift3");
    chk("lock_offset3", OFFSET_O, 3);
    @(negedge PCLKX1_i);
    chk("lock_de0", DE_O, 0);
    chk("lock_c1c0", {C1_O, C0_O}, 0);

    sym_q.push_back(10'h100);
    sym_q.push_back(10'h2FF);
    sym_q.push_back(10'h2AB);
    n = 0;
    while (DE_O !== 1'b1 && n < 30) begin @(negedge PCLKX1_i); n++; end
    chk("data0_de", DE_O, 1);
    chk("data0_d", D_O, 8'h00);
    @(negedge PCLKX1_i);
    chk("data1_de", DE_O, 1);
    chk("data1_d", D_O, 8'hFE);
    @(negedge PCLKX1_i);
    chk("tok11_de", DE_O, 0);
    chk("tok11_c1c0", {C1_O, C0_O}, 3);

    fill_tok = 0;
    wait_lock(0, 400, "timeout_drop");
    chk("timeout_offset", OFFSET_O, 4);
    @(negedge PCLKX1_i);
    chk("timeout_de0", DE_O, 0);
    chk("timeout_d0", D_O, 0);

    shift = 8; regen = 1; fill_tok = 1;
    wait_lock(1, 600, "lock_shift8");
    chk("lock_offset8", OFFSET_O, 8);
    fill_tok = 0;
    wait_lock(0, 400, "drop_to9");
    chk("drop_offset9", OFFSET_O, 9);
    wait_off(0, 100, "wrap_9_to_0");

    shift = 9; regen = 1; fill_tok = 1;
    wait_lock(1, 900, "lock_shift9");
    chk("lock_offset9", OFFSET_O, 9);

    repeat (5) @(negedge PCLKX1_i);
    @(posedge PCLKX1_i);
    #2 RSTn_i = 1'b0;
    #1;
    chk("pulse_locked", LOCKED_O, 0);
    chk("pulse_offset", OFFSET_O, 0);
    chk("pulse_de", DE_O, 0);
    chk("pulse_c1c0", {C1_O, C0_O}, 0);
    #1 RSTn_i = 1'b1;
    shift = 3; regen = 1;
    wait_lock(1, 400, "relock_shift3");
    chk("relock_offset3", OFFSET_O, 3);

    repeat (4) @(negedge PCLKX1_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
